// File: rtl/pic_ctrl_seq.sv
// pic_ctrl_seq: ICW/OCW write decode and INTA acknowledge sequencing for an 8259-style interrupt controller
module pic_ctrl_seq #(
  parameter int NUM_IRQ = 8,
  localparam int IDX_W = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_stb,
  input  logic               a0,
  input  logic [7:0]         din,
  input  logic               inta_n,
  input  logic               req_valid,
  input  logic [IDX_W-1:0]   req_idx,
  input  logic [IDX_W-1:0]   isr_top_idx,
  input  logic               isr_any,
  output logic               int_out,
  output logic [NUM_IRQ-1:0] mask_out,
  output logic [NUM_IRQ-1:0] irr_clr,
  output logic [NUM_IRQ-1:0] isr_set,
  output logic [NUM_IRQ-1:0] isr_clr,
  output logic [7:0]         vector_out,
  output logic               vector_valid,
  output logic               init_done
);
  typedef enum logic [2:0] {UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;
  state_t state;
  logic [1:0] icw1, icw4, ack_cnt;
  logic [7:IDX_W] icw2;
  logic [IDX_W-1:0] idx;
  logic spur, inta_q, is_icw1, ocw2, inta_edge, ack_last, aeoi;
  logic [NUM_IRQ-1:0] eoi_mask;
  function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(NUM_IRQ-1){1'b0}}, 1'b1} << i;
  endfunction
  always_comb begin
    is_icw1 = wr_stb & ~a0 & din[4];
    ocw2 = wr_stb & ~a0 & (din[4:3] == 2'b00) & (state == READY);
    inta_edge = inta_q & ~inta_n & (state == READY);
    ack_last = (ack_cnt != 2'd0) & (ack_cnt == (icw4[0] ? 2'd1 : 2'd2));
    aeoi = inta_edge & ack_last & icw4[1] & ~spur;
    eoi_mask = (ocw2 & (din[7:5] == 3'b001) & isr_any ? onehot(isr_top_idx) : '0)
             | (ocw2 & (din[7:5] == 3'b011) ? onehot(din[IDX_W-1:0]) : '0)
             | (aeoi ? onehot(idx) : '0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= UNINIT;
      icw1 <= '0;
      icw2 <= '0;
      icw4 <= '0;
      ack_cnt <= '0;
      idx <= '0;
      spur <= 1'b0;
      inta_q <= 1'b1;
      int_out <= 1'b0;
      mask_out <= '1;
      irr_clr <= '0;
      isr_set <= '0;
      isr_clr <= '0;
      vector_out <= '0;
      vector_valid <= 1'b0;
      init_done <= 1'b0;
    end else begin
      inta_q <= inta_n;
      irr_clr <= '0;
      isr_set <= '0;
      vector_valid <= 1'b0;
      isr_clr <= is_icw1 ? '0 : eoi_mask;
      int_out <= ~is_icw1 & (state == READY) & req_valid & (ack_cnt == 2'd0);
      // ICW1 restarts initialisation and overrides any acknowledge edge in the same cycle
      if (is_icw1) begin
        icw1 <= din[1:0];
        icw4 <= '0;
        ack_cnt <= '0;
        mask_out <= '1;
        state <= WAIT_ICW2;
        init_done <= 1'b0;
      end else begin
        if (wr_stb)
          case (state)
            WAIT_ICW2: begin
              icw2 <= din[7:IDX_W];
              state <= !icw1[1] ? WAIT_ICW3 : icw1[0] ? WAIT_ICW4 : READY;
              init_done <= icw1[1] & ~icw1[0];
            end
            WAIT_ICW3: begin
              state <= icw1[0] ? WAIT_ICW4 : READY;
              init_done <= ~icw1[0];
            end
            WAIT_ICW4: begin
              icw4 <= din[1:0];
              state <= READY;
              init_done <= 1'b1;
            end
            READY: if (a0) mask_out <= din[NUM_IRQ-1:0];
            default: ;
          endcase
        if (inta_edge) begin
          if (ack_cnt == 2'd0) begin
            idx <= req_valid ? req_idx : '1;
            spur <= ~req_valid;
            ack_cnt <= 2'd1;
            isr_set <= req_valid ? onehot(req_idx) : '0;
            irr_clr <= req_valid ? onehot(req_idx) : '0;
          end else if (ack_last) begin
            vector_out <= {icw2, idx};
            vector_valid <= 1'b1;
            ack_cnt <= 2'd0;
          end else
            ack_cnt <= ack_cnt + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pic_ctrl_seq.sv
// tb_pic_ctrl_seq: transaction-level reference model checking pic_ctrl_seq at NUM_IRQ=8 and NUM_IRQ=4
module tb_pic_ctrl_seq;
  logic clk = 0, reset = 0, wr_stb = 0, a0 = 0, inta_n = 1, req_valid = 0, isr_any = 0;
  logic [7:0] din = 0;
  logic [2:0] req_idx = 0, isr_top_idx = 0;
  logic int_out, vector_valid, init_done, int_out4, vector_valid4, init_done4;
  logic [7:0] mask_out, irr_clr, isr_set, isr_clr, vector_out, vector_out4;
  logic [3:0] mask_out4, irr_clr4, isr_set4, isr_clr4;
  int checks = 0, passed = 0;
  int m_step, m_pulses;
  logic [7:0] m_icw1, m_icw2, m_icw4, m_mask, m_vec, m_vec4;
  logic [2:0] m_idx;
  logic [1:0] m_idx4;
  logic m_spur;

  pic_ctrl_seq #(.NUM_IRQ(8)) dut (
    .clk(clk), .reset(reset), .wr_stb(wr_stb), .a0(a0), .din(din), .inta_n(inta_n),
    .req_valid(req_valid), .req_idx(req_idx), .isr_top_idx(isr_top_idx), .isr_any(isr_any),
    .int_out(int_out), .mask_out(mask_out), .irr_clr(irr_clr), .isr_set(isr_set), .isr_clr(isr_clr),
    .vector_out(vector_out), .vector_valid(vector_valid), .init_done(init_done));

  pic_ctrl_seq #(.NUM_IRQ(4)) dut4 (
    .clk(clk), .reset(reset), .wr_stb(wr_stb), .a0(a0), .din(din), .inta_n(inta_n),
    .req_valid(req_valid), .req_idx(req_idx[1:0]), .isr_top_idx(isr_top_idx[1:0]), .isr_any(isr_any),
    .int_out(int_out4), .mask_out(mask_out4), .irr_clr(irr_clr4), .isr_set(isr_set4), .isr_clr(isr_clr4),
    .vector_out(vector_out4), .vector_valid(vector_valid4), .init_done(init_done4));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_step = 0; m_pulses = 0; m_icw1 = 0; m_icw2 = 0; m_icw4 = 0;
    m_mask = 8'hFF; m_vec = 0; m_vec4 = 0; m_idx = 0; m_idx4 = 0; m_spur = 0;
  endtask

  // Step 0 = uninitialised, 2..4 = waiting for that ICW, 5 = ready
  task automatic do_write(input logic a, input logic [7:0] d);
    logic [7:0] e_clr;
    logic [3:0] e_clr4;
    e_clr = 0;
    e_clr4 = 0;
    if (!a && d[4]) begin
      m_icw1 = d; m_icw4 = 0; m_pulses = 0; m_mask = 8'hFF; m_step = 2;
    end else if (m_step == 2) begin
      m_icw2 = d;
      m_step = !m_icw1[1] ? 3 : m_icw1[0] ? 4 : 5;
    end else if (m_step == 3) m_step = m_icw1[0] ? 4 : 5;
    else if (m_step == 4) begin
      m_icw4 = d; m_step = 5;
    end else if (m_step == 5) begin
      if (a) m_mask = d;
      else if (d[4:3] == 2'b00) begin
        if (d[7:5] == 3'd1 && isr_any) begin e_clr = 8'd1 << isr_top_idx; e_clr4 = 4'd1 << isr_top_idx[1:0]; end
        if (d[7:5] == 3'd3) begin e_clr = 8'd1 << d[2:0]; e_clr4 = 4'd1 << d[1:0]; end
      end
    end
    wr_stb = 1; a0 = a; din = d;
    tick;
    wr_stb = 0;
    checks++; if (init_done !== (m_step == 5)) $display("FAIL wr_init_done d=%h got %b want %b", d, init_done, m_step == 5); else passed++;
    checks++; if (init_done4 !== (m_step == 5)) $display("FAIL wr_init_done4 d=%h got %b want %b", d, init_done4, m_step == 5); else passed++;
    checks++; if (mask_out !== m_mask) $display("FAIL wr_mask d=%h got %h want %h", d, mask_out, m_mask); else passed++;
    checks++; if (mask_out4 !== m_mask[3:0]) $display("FAIL wr_mask4 d=%h got %h want %h", d, mask_out4, m_mask[3:0]); else passed++;
    checks++; if (isr_clr !== e_clr) $display("FAIL wr_isr_clr d=%h got %h want %h", d, isr_clr, e_clr); else passed++;
    checks++; if (isr_clr4 !== e_clr4) $display("FAIL wr_isr_clr4 d=%h got %h want %h", d, isr_clr4, e_clr4); else passed++;
    checks++; if (vector_valid !== 1'b0) $display("FAIL wr_vector_valid got %b want 0", vector_valid); else passed++;
  endtask

  task automatic do_inta;
    logic [7:0] e_set, e_clr;
    logic [3:0] e_set4, e_clr4;
    logic e_vv, e_int;
    e_set = 0; e_clr = 0; e_set4 = 0; e_clr4 = 0; e_vv = 0;
    if (m_step == 5) begin
      if (m_pulses == 0) begin
        m_spur = !req_valid;
        m_idx = req_valid ? req_idx : 3'd7;
        m_idx4 = req_valid ? req_idx[1:0] : 2'd3;
        if (req_valid) begin e_set = 8'd1 << m_idx; e_set4 = 4'd1 << m_idx4; end
        m_pulses = 1;
      end else if (m_pulses + 1 == (m_icw4[0] ? 2 : 3)) begin
        e_vv = 1;
        m_pulses = 0;
        m_vec = (m_icw2 & 8'hF8) | 8'(m_idx);
        m_vec4 = (m_icw2 & 8'hFC) | 8'(m_idx4);
        if (m_icw4[1] && !m_spur) begin e_clr = 8'd1 << m_idx; e_clr4 = 4'd1 << m_idx4; end
      end else m_pulses++;
    end
    inta_n = 0;
    tick;
    checks++; if (isr_set !== e_set) $display("FAIL ack_isr_set got %h want %h", isr_set, e_set); else passed++;
    checks++; if (irr_clr !== e_set) $display("FAIL ack_irr_clr got %h want %h", irr_clr, e_set); else passed++;
    checks++; if (isr_clr !== e_clr) $display("FAIL ack_isr_clr got %h want %h", isr_clr, e_clr); else passed++;
    checks++; if (vector_valid !== e_vv) $display("FAIL ack_vector_valid got %b want %b", vector_valid, e_vv); else passed++;
    checks++; if (vector_out !== m_vec) $display("FAIL ack_vector got %h want %h", vector_out, m_vec); else passed++;
    checks++; if (isr_set4 !== e_set4) $display("FAIL ack_isr_set4 got %h want %h", isr_set4, e_set4); else passed++;
    checks++; if (irr_clr4 !== e_set4) $display("FAIL ack_irr_clr4 got %h want %h", irr_clr4, e_set4); else passed++;
    checks++; if (isr_clr4 !== e_clr4) $display("FAIL ack_isr_clr4 got %h want %h", isr_clr4, e_clr4); else passed++;
    checks++; if (vector_valid4 !== e_vv) $display("FAIL ack_vector_valid4 got %b want %b", vector_valid4, e_vv); else passed++;
    checks++; if (vector_out4 !== m_vec4) $display("FAIL ack_vector4 got %h want %h", vector_out4, m_vec4); else passed++;
    inta_n = 1;
    tick;
    e_int = (m_step == 5) && req_valid && (m_pulses == 0);
    checks++; if (vector_valid !== 1'b0 || isr_set !== 8'h00) $display("FAIL ack_strobe_len got vv=%b set=%h want 0", vector_valid, isr_set); else passed++;
    checks++; if (int_out !== e_int) $display("FAIL ack_int_out got %b want %b", int_out, e_int); else passed++;
    checks++; if (int_out4 !== e_int) $display("FAIL ack_int_out4 got %b want %b", int_out4, e_int); else passed++;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) tick;
    checks++; if (int_out !== 1'b0) $display("FAIL rst_int_out got %b want 0", int_out); else passed++;
    checks++; if (mask_out !== 8'hFF) $display("FAIL rst_mask got %h want ff", mask_out); else passed++;
    checks++; if (mask_out4 !== 4'hF) $display("FAIL rst_mask4 got %h want f", mask_out4); else passed++;
    checks++; if ({irr_clr, isr_set, isr_clr} !== 24'h0) $display("FAIL rst_strobes got %h want 0", {irr_clr, isr_set, isr_clr}); else passed++;
    checks++; if (vector_out !== 8'h00) $display("FAIL rst_vector got %h want 00", vector_out); else passed++;
    checks++; if (vector_valid !== 1'b0) $display("FAIL rst_vector_valid got %b want 0", vector_valid); else passed++;
    checks++; if (init_done !== 1'b0) $display("FAIL rst_init_done got %b want 0", init_done); else passed++;
    reset = 0;
    model_reset;
  endtask

  task automatic test_reset_mid;
    do_write(0, 8'h13);
    do_write(1, 8'h40);
    reset = 1;
    #2;
    checks++; if (mask_out !== 8'hFF) $display("FAIL mid_rst_mask got %h want ff", mask_out); else passed++;
    checks++; if (init_done !== 1'b0 || int_out !== 1'b0) $display("FAIL mid_rst_flags got %b%b want 00", init_done, int_out); else passed++;
    tick;
    reset = 0;
    model_reset;
    do_write(1, 8'h00);
    do_write(1, 8'h01);
  endtask

  task automatic test_init;
    do_write(0, 8'h13);
    do_write(1, 8'h40);
    do_write(1, 8'h01);
    do_write(0, 8'h12);
    do_write(1, 8'h40);
    do_write(0, 8'h11);
    do_write(1, 8'h40);
    do_write(1, 8'hAA);
    do_write(1, 8'h03);
  endtask

  task automatic test_8086;
    do_write(0, 8'h13);
    do_write(1, 8'h40);
    do_write(1, 8'h01);
    req_valid = 1; req_idx = 3'd5;
    tick;
    checks++; if (int_out !== 1'b1) $display("FAIL x86_int_out got %b want 1", int_out); else passed++;
    do_inta;
    do_inta;
    checks++; if (vector_out !== 8'h45) $display("FAIL x86_vector got %h want 45", vector_out); else passed++;
  endtask

  task automatic test_8080_aeoi;
    do_write(0, 8'h13);
    do_write(1, 8'h48);
    do_write(1, 8'h02);
    req_valid = 1; req_idx = 3'd2;
    tick;
    repeat (3) do_inta;
    checks++; if (vector_out4 !== 8'h4A) $display("FAIL x80_vector4 got %h want 4a", vector_out4); else passed++;
    checks++; if (vector_out !== 8'h4A) $display("FAIL x80_vector got %h want 4a", vector_out); else passed++;
    req_valid = 0;
    tick;
    repeat (3) do_inta;
    checks++; if (vector_out4 !== 8'h4B) $display("FAIL spur_vector4 got %h want 4b", vector_out4); else passed++;
    checks++; if (vector_out !== 8'h4F) $display("FAIL spur_vector got %h want 4f", vector_out); else passed++;
  endtask

  task automatic test_ocw;
    isr_top_idx = 3'd3; isr_any = 1;
    do_write(1, 8'hF0);
    checks++; if (mask_out !== 8'hF0) $display("FAIL ocw1_mask got %h want f0", mask_out); else passed++;
    do_write(0, 8'h20);
    do_write(0, 8'h66);
    isr_any = 0;
    do_write(0, 8'h20);
    do_write(0, 8'h40);
  endtask

  task automatic test_back_to_back;
    do_write(0, 8'h13);
    do_write(1, 8'h40);
    do_write(1, 8'h03);
    req_valid = 1; req_idx = 3'd6;
    tick;
    do_inta;
    inta_n = 0; wr_stb = 1; a0 = 0; din = 8'h61;
    tick;
    checks++; if (isr_clr !== 8'h42) $display("FAIL or_isr_clr got %h want 42", isr_clr); else passed++;
    checks++; if (isr_clr4 !== 4'h6) $display("FAIL or_isr_clr4 got %h want 6", isr_clr4); else passed++;
    checks++; if (vector_valid !== 1'b1 || vector_out !== 8'h46) $display("FAIL or_vector got %b/%h want 1/46", vector_valid, vector_out); else passed++;
    wr_stb = 0; inta_n = 1;
    tick;
    m_pulses = 0; m_vec = 8'h46; m_vec4 = 8'h42;
    do_inta;
    inta_n = 0; wr_stb = 1; a0 = 0; din = 8'h12;
    tick;
    checks++; if (vector_valid !== 1'b0 || isr_clr !== 8'h00) $display("FAIL icw1_wins got vv=%b clr=%h want 0", vector_valid, isr_clr); else passed++;
    checks++; if (init_done !== 1'b0 || mask_out !== 8'hFF) $display("FAIL icw1_reinit got %b/%h want 0/ff", init_done, mask_out); else passed++;
    wr_stb = 0; inta_n = 1;
    tick;
    m_icw1 = 8'h12; m_icw4 = 0; m_pulses = 0; m_mask = 8'hFF; m_step = 2;
    do_inta;
    do_write(1, 8'h40);
    repeat (3) do_inta;
    checks++; if (vector_out !== 8'h46) $display("FAIL reinit_vector got %h want 46", vector_out); else passed++;
  endtask

  task automatic test_random;
    logic [7:0] w;
    logic e_int;
    w = 8'($urandom);
    do_write(0, {w[7:5], 1'b1, w[3:0]});
    repeat (3) do_write(1, 8'($urandom));
    for (int i = 0; i < 60; i++) begin
      req_valid = 1'($urandom); req_idx = 3'($urandom);
      case ($urandom_range(0, 5))
        0: begin
          w = 8'($urandom);
          do_write(0, {w[7:5], 1'b1, w[3:0]});
          repeat ($urandom_range(1, 3)) do_write(1, 8'($urandom));
        end
        1: do_write(1, 8'($urandom));
        2: begin
          isr_top_idx = 3'($urandom); isr_any = 1'($urandom); w = 8'($urandom);
          do_write(0, {w[7:5], 2'b00, w[2:0]});
        end
        3, 4: do_inta;
        default: begin
          tick;
          e_int = (m_step == 5) && req_valid && (m_pulses == 0);
          checks++; if (int_out !== e_int) $display("FAIL rnd_int_out got %b want %b", int_out, e_int); else passed++;
        end
      endcase
    end
  endtask

  initial begin
    model_reset;
    test_reset;
    test_reset_mid;
    test_init;
    test_8086;
    test_8080_aeoi;
    test_ocw;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pic_ctrl_seq.md
Name: pic_ctrl_seq

Overview:
- Synchronous, parametrised successor of the interrupt controller's control logic.
- Decodes the ICW1–ICW4 initialisation sequence and OCW1/OCW2 writes, and runs the INTA acknowledge sequence in 8086 (2-pulse) or 8080 (3-pulse) mode.
- Drives INT, the vector, ISR set/clear and IRR clear strobes, with optional auto-EOI.
- Sits between the read/write logic and data bus buffer on one side and the IRR/ISR/priority resolver on the other.

Parameters:
NUM_IRQ, 8, number of interrupt request lines; power of two, 2..8.
IDX_W, $clog2(NUM_IRQ), width of the request index; derived, not overridden.

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
wr_stb  in  1  one-cycle write strobe from read/write logic.
a0  in  1  address bit qualifying wr_stb.
din  in  8  data bus write value, valid with wr_stb.
inta_n  in  1  acknowledge input, active-low, synchronous to clk.
req_valid  in  1  resolver reports an unmasked, unblocked request.
req_idx  in  IDX_W  resolver's highest-priority request index.
isr_top_idx  in  IDX_W  highest-priority in-service index, for non-specific EOI.
isr_any  in  1  at least one ISR bit set.
int_out  out  1  interrupt request to CPU.
mask_out  out  NUM_IRQ  OCW1 interrupt mask register.
irr_clr  out  NUM_IRQ  one-cycle one-hot IRR clear.
isr_set  out  NUM_IRQ  one-cycle one-hot ISR set.
isr_clr  out  NUM_IRQ  one-cycle one-hot ISR clear.
vector_out  out  8  interrupt vector.
vector_valid  out  1  one-cycle; vector_out drives the bus this cycle.
init_done  out  1  initialisation complete.

Behaviour:

Reset (async, active-high):
- All outputs 0; mask_out all-ones.
- icw1, icw2, icw4 = 0.
- Init FSM = UNINIT; ack counter = 0.

Write decode (only on wr_stb cycles):
- a0=0 with din[4]=1 is ICW1.
  - Accepted in any state, including mid-init and mid-ack.
  - Loads icw1 and clears icw4.
  - Aborts any ack sequence (counter to 0, no strobes).
  - Sets mask_out to all-ones; FSM to WAIT_ICW2; init_done to 0.

Init FSM:
- States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- WAIT_ICW2, on write: load icw2 (a0 is don't-care).
  - icw1[1]=0 (cascade) → WAIT_ICW3.
  - Else icw1[0]=1 → WAIT_ICW4.
  - Else → READY.
- WAIT_ICW3, on write: data discarded (no cascade support).
  - icw1[0]=1 → WAIT_ICW4.
  - Else → READY.
- WAIT_ICW4, on write: load icw4 → READY.
- init_done = 1 exactly while in READY (registered, same edge as the transition).

In READY:
- a0=1 write is OCW1: mask_out ← din[NUM_IRQ-1:0].
- a0=0, din[4:3]=00 write is OCW2, on din[7:5]:
  - 001: non-specific EOI. isr_clr ← onehot(isr_top_idx) if isr_any, else no pulse.
  - 011: specific EOI. isr_clr ← onehot(din[IDX_W-1:0]).
  - Other codes: ignored.
- Writes in UNINIT other than ICW1 are ignored.

INT:
- int_out is registered: int_out ← (READY & req_valid & ack_cnt==0).
- Drops on the clock after the first INTA falling edge is detected.

INTA sequence:
- A falling edge of inta_n is detected with one register (inta_n was 1 last cycle, 0 now).
- Required pulse count N: 2 if icw4[0]=1, else 3.
- First edge:
  - Latch idx ← req_idx if req_valid, else spurious idx = NUM_IRQ-1.
  - If not spurious: pulse isr_set and irr_clr (onehot(idx)) in the following cycle.
  - ack_cnt ← 1.
- Intermediate edges: ack_cnt increments.
- N-th edge:
  - vector_out ← {icw2[7:IDX_W], idx}, held until the next vector.
  - vector_valid pulses one cycle.
  - ack_cnt ← 0.
  - If icw4[1]=1 (AEOI) and not spurious, isr_clr ← onehot(idx) in the same cycle.
- INTA edges outside READY are ignored.

Simultaneous events:
- ICW1 write wins over any INTA edge in the same cycle.
- An OCW2 EOI in the same cycle as an AEOI clear ORs both one-hot strobes.

Width rule: the vector keeps icw2 bits above IDX_W and replaces the low IDX_W bits with idx.

Test Plan:
- Reset mid-sequence: assert reset after ICW1 and ICW2 → next cycle all outputs 0, mask all-ones; ICW3 write is ignored (FSM in UNINIT).
- Init: ICW1=0x13 (single, ICW4), ICW2=0x40, ICW4=0x01 → init_done=1 after the third write. ICW1=0x12 → init_done after ICW2.
- 8086 ack, NUM_IRQ=8: req_valid=1, req_idx=5 → int_out=1. Two INTA pulses → isr_set=irr_clr=0x20 after the first; vector_out=0x45 with vector_valid on the second; int_out low throughout.
- 8080 mode plus AEOI (ICW4=0x02), NUM_IRQ=4, ICW2=0x48, req_idx=2 → vector 0x4A on the third pulse with isr_clr=0x4. Spurious (req_valid=0) → vector 0x4B, no isr_set and no isr_clr.
- OCW: OCW1 0xF0 → mask_out=0xF0. OCW2 0x20 with isr_top_idx=3, isr_any=1 → isr_clr=0x08. OCW2 0x66 → isr_clr=0x40. OCW2 0x20 with isr_any=0 → no pulse.
- Re-init mid-ack: ICW1 between INTA pulses → no vector_valid, ack_cnt=0, init_done=0, mask=0xFF.
